gauss_blur3x3: RTL

GAUSS_BLUR3X3 -- requirements
Module: gauss_blur3x3

---
 rtl/gauss_blur3x3.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/gauss_blur3x3.sv
// Streaming 3x3 Gaussian blur for RGB555 video. Two line buffers hold the previous
// two rows; a two-column window plus the incoming column forms the 3x3 neighbourhood.
`timescale 1ns/1ps
module gauss_blur3x3 #(
  parameter int LINE_W = 400,
  parameter int LINES  = 100
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_frame_start,
  input  logic        i_valid,
  input  logic [14:0] i_pixel,
  output logic        o_valid,
  output logic [14:0] o_pixel,
  output logic        o_frame_done,
  output logic        o_busy
);

  localparam int CW = (LINE_W > 1) ? $clog2(LINE_W) : 1;
  localparam int RW = (LINES > 1) ? $clog2(LINES) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(LINE_W - 1);
  localparam logic [CW-1:0] COL_TWO  = CW'(2);
  localparam logic [RW-1:0] ROW_LAST = RW'(LINES - 1);
  localparam logic [RW-1:0] ROW_ONE  = RW'(1);
  localparam logic [RW-1:0] ROW_TWO  = RW'(2);

  typedef enum logic [1:0] {IDLE, FILL, RUN, DONE} state_t;

  state_t state_q, state_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic          valid_q, valid_d;
  logic [14:0]   pixel_q, pixel_d;
  logic          done_q, done_d;
  logic          busy_q, busy_d;
  // win_q[0] holds column c-2, win_q[1] column c-1; index [0] is the oldest row
  logic [1:0][2:0][14:0] win_q, win_d;

  logic [14:0] lb0_q [LINE_W];
  logic [14:0] lb1_q [LINE_W];

  logic          accept;
  logic [CW-1:0] acc_col;
  logic [RW-1:0] acc_row;
  logic [14:0]   top_px;
  logic [14:0]   mid_px;

  function automatic logic [14:0] blur(
    input logic [14:0] t0, input logic [14:0] t1, input logic [14:0] t2,
    input logic [14:0] m0, input logic [14:0] m1, input logic [14:0] m2,
    input logic [14:0] b0, input logic [14:0] b1, input logic [14:0] b2
  );
    logic [8:0]  sum;
    logic [14:0] res;
    res = '0;
    for (int ch = 0; ch < 3; ch++) begin
      sum = {4'd0, t0[ch*5 +: 5]} + {3'd0, t1[ch*5 +: 5], 1'b0} + {4'd0, t2[ch*5 +: 5]}
          + {3'd0, m0[ch*5 +: 5], 1'b0} + {2'd0, m1[ch*5 +: 5], 2'b0} + {3'd0, m2[ch*5 +: 5], 1'b0}
          + {4'd0, b0[ch*5 +: 5]} + {3'd0, b1[ch*5 +: 5], 1'b0} + {4'd0, b2[ch*5 +: 5]};
      res[ch*5 +: 5] = sum[8:4];
    end
    return res;
  endfunction

  always_comb begin
    accept  = i_valid && ((i_frame_start && state_q != DONE) ||
                          state_q == FILL || state_q == RUN);
    acc_col = i_frame_start ? '0 : col_q;
    acc_row = i_frame_start ? '0 : row_q;
    top_px  = lb1_q[acc_col];
    mid_px  = lb0_q[acc_col];

    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    win_d   = win_q;
    valid_d = 1'b0;
    pixel_d = pixel_q;
    done_d  = 1'b0;

    if (state_q == DONE) begin
      state_d = IDLE;
    end else if (i_frame_start) begin
      state_d = FILL;
      col_d   = '0;
      row_d   = '0;
    end

    // Columns left over from the previous row are shifted out before c reaches 2,
    // so a window that produces output only ever holds current-row columns.
    if (accept) begin
      win_d[0] = win_q[1];
      win_d[1] = {i_pixel, mid_px, top_px};
      if (acc_row >= ROW_TWO && acc_col >= COL_TWO) begin
        valid_d = 1'b1;
        pixel_d = blur(win_q[0][0], win_q[1][0], top_px,
                       win_q[0][1], win_q[1][1], mid_px,
                       win_q[0][2], win_q[1][2], i_pixel);
      end
      if (acc_col == COL_LAST) begin
        col_d = '0;
        row_d = acc_row + 1'b1;
      end else begin
        col_d = acc_col + 1'b1;
        row_d = acc_row;
      end
      if (acc_row == ROW_ONE && acc_col == COL_LAST) state_d = RUN;
      if (acc_row == ROW_LAST && acc_col == COL_LAST) begin
        state_d = DONE;
        done_d  = 1'b1;
        col_d   = '0;
        row_d   = '0;
      end
    end

    busy_d = (state_d == FILL) || (state_d == RUN);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      col_q   <= '0;
      row_q   <= '0;
      win_q   <= '0;
      valid_q <= 1'b0;
      pixel_q <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      win_q   <= win_d;
      valid_q <= valid_d;
      pixel_q <= pixel_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  // Line buffers are not reset: FILL overwrites every entry before it is read.
  always_ff @(posedge i_clk) begin
    if (accept) begin
      lb1_q[acc_col] <= mid_px;
      lb0_q[acc_col] <= i_pixel;
    end
  end

  assign o_valid      = valid_q;
  assign o_pixel      = pixel_q;
  assign o_frame_done = done_q;
  assign o_busy       = busy_q;

endmodule
